// File: rtl/seg_mmu_pkg.sv
// Shared definitions for the segmented MMU: memory-op encodings, FSM states
// and the default legal instruction/data windows.
package mmu_pkg;

   localparam logic [1:0] MEM_IDLE = 2'b00;
   localparam logic [1:0] MEM_RD   = 2'b01;
   localparam logic [1:0] MEM_WR   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [31:0] IMEM_BASE_DEF  = 32'h0001_0000;
   localparam logic [31:0] IMEM_LIMIT_DEF = 32'h0001_01FF;
   localparam logic [31:0] DMEM_BASE_DEF  = 32'h0001_0200;
   localparam logic [31:0] DMEM_LIMIT_DEF = 32'h0001_02FF;

endpackage

// File: rtl/seg_mmu_if.sv
// Core, memory-controller and status signals of the segmented MMU.
// slave is the MMU view; master is the view of the core/controller side.
interface seg_mmu_if #(
   parameter int NUM_THRD = 8
);
   localparam int TW = (NUM_THRD > 1) ? $clog2(NUM_THRD) : 1;

   logic [31:0]         i_addr;
   logic                i_rd;
   logic [TW-1:0]       i_trd;
   logic                i_miss;
   logic                i_done;
   logic                i_segfault;

   logic [31:0]         d_addr;
   logic [31:0]         d_wr_data;
   logic                d_rd;
   logic                d_wr;
   logic [TW-1:0]       d_trd;
   logic                d_miss;
   logic                d_done;
   logic                d_segfault;

   logic                ready;
   logic                tx_done;
   logic [1:0]          mem_op;
   logic [63:0]         cpu_addr;
   logic [31:0]         mem_wr_data;

   logic                seg_clr;
   logic [TW-1:0]       seg_clr_trd;
   logic [NUM_THRD-1:0] i_seg_sts;
   logic [NUM_THRD-1:0] d_seg_sts;

   modport slave (
      input  i_addr, i_rd, i_trd, d_addr, d_wr_data, d_rd, d_wr, d_trd,
      input  ready, tx_done, seg_clr, seg_clr_trd,
      output i_miss, i_done, i_segfault, d_miss, d_done, d_segfault,
      output mem_op, cpu_addr, mem_wr_data, i_seg_sts, d_seg_sts
   );

   modport master (
      output i_addr, i_rd, i_trd, d_addr, d_wr_data, d_rd, d_wr, d_trd,
      output ready, tx_done, seg_clr, seg_clr_trd,
      input  i_miss, i_done, i_segfault, d_miss, d_done, d_segfault,
      input  mem_op, cpu_addr, mem_wr_data, i_seg_sts, d_seg_sts
   );

endinterface

// File: rtl/seg_mmu_seg_chk.sv
// Inclusive window check: flags a valid access whose address lies outside
// [BASE, LIMIT].
module seg_chk #(
   parameter logic [31:0] BASE  = 32'h0000_0000,
   parameter logic [31:0] LIMIT = 32'hFFFF_FFFF
) (
   input  logic [31:0] addr,
   input  logic        vld,
   output logic        fault
);

   assign fault = vld & ((addr < BASE) | (addr > LIMIT));

endmodule

// File: rtl/seg_mmu.sv
// Segmented MMU: window-checks instruction/data requests and forwards legal
// ones to a single memory controller. Define SEG_MMU_RR_ARB_EN for round-robin.
module seg_mmu
   import mmu_pkg::*;
#(
   parameter int          NUM_THRD   = 8,
   parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
   parameter logic [31:0] IMEM_LIMIT = IMEM_LIMIT_DEF,
   parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
   parameter logic [31:0] DMEM_LIMIT = DMEM_LIMIT_DEF
) (
   input logic      clk,
   input logic      rst_n,
   seg_mmu_if.slave bus
);

   state_t              state;
   logic                gnt_d;
   logic                i_fault, d_fault;
   logic                i_req, d_req, pick_d;
   logic [NUM_THRD-1:0] i_set, d_set, clr;

   seg_chk #(.BASE(IMEM_BASE), .LIMIT(IMEM_LIMIT)) u_i_chk (
      .addr  (bus.i_addr),
      .vld   (bus.i_rd),
      .fault (i_fault)
   );

   seg_chk #(.BASE(DMEM_BASE), .LIMIT(DMEM_LIMIT)) u_d_chk (
      .addr  (bus.d_addr),
      .vld   (bus.d_rd | bus.d_wr),
      .fault (d_fault)
   );

   assign bus.i_segfault = i_fault;
   assign bus.d_segfault = d_fault;

   assign i_req = bus.i_rd & ~i_fault;
   assign d_req = (bus.d_rd | bus.d_wr) & ~d_fault;

   // done follows tx_done combinationally so miss can drop in the same cycle
   assign bus.i_done = (state == WAIT) & bus.tx_done & ~gnt_d;
   assign bus.d_done = (state == WAIT) & bus.tx_done & gnt_d;
   assign bus.i_miss = i_req & ~bus.i_done;
   assign bus.d_miss = d_req & ~bus.d_done;

`ifdef SEG_MMU_RR_ARB_EN
   logic last_gnt_d;

   assign pick_d = d_req & (~i_req | ~last_gnt_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_gnt_d <= 1'b0;
      else if (state == IDLE && (d_req | i_req))
         last_gnt_d <= pick_d;
   end
`else
   assign pick_d = d_req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         gnt_d           <= 1'b0;
         bus.mem_op      <= MEM_IDLE;
         bus.cpu_addr    <= '0;
         bus.mem_wr_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (d_req | i_req) begin
                  state <= ISSUE;
                  gnt_d <= pick_d;
                  if (pick_d) begin
                     bus.cpu_addr    <= {32'b0, bus.d_addr};
                     bus.mem_op      <= bus.d_wr ? MEM_WR : MEM_RD;
                     bus.mem_wr_data <= bus.d_wr_data;
                  end else begin
                     bus.cpu_addr <= {32'b0, bus.i_addr};
                     bus.mem_op   <= MEM_RD;
                  end
               end
            end
            ISSUE: begin
               if (bus.ready) begin
                  state      <= WAIT;
                  bus.mem_op <= MEM_IDLE;
               end
            end
            WAIT: begin
               if (bus.tx_done)
                  state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               bus.mem_op <= MEM_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      i_set = '0;
      d_set = '0;
      clr   = '0;
      if (i_fault)
         i_set[bus.i_trd] = 1'b1;
      if (d_fault)
         d_set[bus.d_trd] = 1'b1;
      if (bus.seg_clr)
         clr[bus.seg_clr_trd] = 1'b1;
   end

   // a set in the same cycle as a clear of that bit wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.i_seg_sts <= '0;
         bus.d_seg_sts <= '0;
      end else begin
         bus.i_seg_sts <= (bus.i_seg_sts & ~clr) | i_set;
         bus.d_seg_sts <= (bus.d_seg_sts & ~clr) | d_set;
      end
   end

endmodule

// File: tb/tb_seg_mmu.sv
// Directed bench for seg_mmu: windows, faults, arbitration, stalls, reset.
module tb_seg_mmu;
   import mmu_pkg::*;

   logic clk;
   logic rst_n;
   int   nvec;
   int   nerr;

   seg_mmu_if #(.NUM_THRD(8)) bus ();

   seg_mmu #(.NUM_THRD(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Grant from IDLE with requests already posted, then complete the transaction.
   task automatic serve(input string tag, input logic [31:0] addr, input logic [1:0] op,
                        input logic is_d);
      tick();
      chk({tag, "_op"}, 64'(bus.mem_op), 64'(op));
      chk({tag, "_addr"}, bus.cpu_addr, {32'h0, addr});
      bus.ready = 1'b1;
      tick();
      chk({tag, "_wait_op"}, 64'(bus.mem_op), 64'(MEM_IDLE));
      bus.ready   = 1'b0;
      bus.tx_done = 1'b1;
      #1;
      chk({tag, "_done"}, 64'(is_d ? bus.d_done : bus.i_done), 64'd1);
      chk({tag, "_miss"}, 64'(is_d ? bus.d_miss : bus.i_miss), 64'd0);
      if (is_d) begin
         bus.d_rd = 1'b0;
         bus.d_wr = 1'b0;
      end else begin
         bus.i_rd = 1'b0;
      end
      tick();
      bus.tx_done = 1'b0;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      rst_n           = 1'b0;
      bus.i_addr      = '0;
      bus.i_rd        = 1'b0;
      bus.i_trd       = '0;
      bus.d_addr      = '0;
      bus.d_wr_data   = '0;
      bus.d_rd        = 1'b0;
      bus.d_wr        = 1'b0;
      bus.d_trd       = '0;
      bus.ready       = 1'b0;
      bus.tx_done     = 1'b0;
      bus.seg_clr     = 1'b0;
      bus.seg_clr_trd = '0;

      // reset state
      tick();
      tick();
      chk("rst_op", 64'(bus.mem_op), 64'(MEM_IDLE));
      chk("rst_addr", bus.cpu_addr, 64'h0);
      chk("rst_wdata", 64'(bus.mem_wr_data), 64'h0);
      chk("rst_done", 64'({bus.i_done, bus.d_done}), 64'h0);
      chk("rst_sts", 64'({bus.i_seg_sts, bus.d_seg_sts}), 64'h0);
      rst_n = 1'b1;
      tick();

      // basic instruction fetch, 3-cycle latency
      bus.i_rd   = 1'b1;
      bus.i_addr = 32'h0001_0004;
      bus.ready  = 1'b1;
      #1;
      chk("if_miss0", 64'(bus.i_miss), 64'd1);
      chk("if_segf", 64'(bus.i_segfault), 64'd0);
      tick();
      chk("if_op", 64'(bus.mem_op), 64'(MEM_RD));
      chk("if_addr", bus.cpu_addr, 64'h0000_0000_0001_0004);
      chk("if_miss1", 64'(bus.i_miss), 64'd1);
      tick();
      chk("if_wait_op", 64'(bus.mem_op), 64'(MEM_IDLE));
      chk("if_nodone", 64'(bus.i_done), 64'd0);
      bus.ready   = 1'b0;
      bus.tx_done = 1'b1;
      #1;
      chk("if_done", 64'(bus.i_done), 64'd1);
      chk("if_miss2", 64'(bus.i_miss), 64'd0);
      bus.i_rd = 1'b0;
      tick();
      bus.tx_done = 1'b0;
      #1;
      chk("if_done_pulse", 64'(bus.i_done), 64'd0);

      // stray tx_done in IDLE
      bus.tx_done = 1'b1;
      #1;
      chk("idle_txd_done", 64'({bus.i_done, bus.d_done}), 64'h0);
      tick();
      bus.tx_done = 1'b0;
      chk("idle_txd_op", 64'(bus.mem_op), 64'(MEM_IDLE));

      // data write fault on thread 3, instruction fault on thread 5
      bus.d_wr   = 1'b1;
      bus.d_addr = 32'h0001_0000;
      bus.d_trd  = 3'd3;
      bus.i_rd   = 1'b1;
      bus.i_addr = 32'h0001_0200;
      bus.i_trd  = 3'd5;
      #1;
      chk("df_segf", 64'(bus.d_segfault), 64'd1);
      chk("df_miss", 64'(bus.d_miss), 64'd0);
      chk("if_segf2", 64'(bus.i_segfault), 64'd1);
      chk("if_miss3", 64'(bus.i_miss), 64'd0);
      tick();
      bus.d_wr = 1'b0;
      bus.i_rd = 1'b0;
      chk("df_op", 64'(bus.mem_op), 64'(MEM_IDLE));
      chk("df_sts", 64'(bus.d_seg_sts), 64'h08);
      chk("if_sts", 64'(bus.i_seg_sts), 64'h20);

      // window boundaries (combinational, no edge crossed)
      bus.d_rd   = 1'b1;
      bus.d_addr = 32'h0001_02FF;
      #1;
      chk("d_lim_segf", 64'(bus.d_segfault), 64'd0);
      chk("d_lim_miss", 64'(bus.d_miss), 64'd1);
      bus.d_addr = 32'h0001_0300;
      #1;
      chk("d_over_segf", 64'(bus.d_segfault), 64'd1);
      bus.d_addr = 32'h0001_01FF;
      #1;
      chk("d_under_segf", 64'(bus.d_segfault), 64'd1);
      bus.d_rd   = 1'b0;
      bus.i_rd   = 1'b1;
      bus.i_addr = 32'h0001_01FF;
      #1;
      chk("i_lim_segf", 64'(bus.i_segfault), 64'd0);
      bus.i_rd = 1'b0;
      #1;
      chk("i_idle_segf", 64'(bus.i_segfault), 64'd0);

      // clear racing a new fault on thread 3 keeps the bit
      bus.seg_clr     = 1'b1;
      bus.seg_clr_trd = 3'd3;
      bus.d_wr        = 1'b1;
      bus.d_addr      = 32'h0001_0000;
      bus.d_trd       = 3'd3;
      tick();
      bus.d_wr = 1'b0;
      chk("clr_race", 64'(bus.d_seg_sts), 64'h08);
      tick();
      chk("clr_d", 64'(bus.d_seg_sts), 64'h00);
      chk("clr_keep_i", 64'(bus.i_seg_sts), 64'h20);
      bus.seg_clr_trd = 3'd5;
      tick();
      bus.seg_clr = 1'b0;
      chk("clr_i", 64'(bus.i_seg_sts), 64'h00);

      // conflict: data first; ready stalls in ISSUE
      bus.d_rd   = 1'b1;
      bus.d_addr = 32'h0001_0210;
      bus.i_rd   = 1'b1;
      bus.i_addr = 32'h0001_0008;
      #1;
      chk("cf_miss", 64'({bus.d_miss, bus.i_miss}), 64'h3);
      tick();
      chk("cf_op", 64'(bus.mem_op), 64'(MEM_RD));
      chk("cf_addr", bus.cpu_addr, 64'h0000_0000_0001_0210);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_op", 64'(bus.mem_op), 64'(MEM_RD));
         chk("stall_done", 64'({bus.i_done, bus.d_done}), 64'h0);
      end
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
      chk("stall_wait_op", 64'(bus.mem_op), 64'(MEM_IDLE));
      bus.tx_done = 1'b1;
      #1;
      chk("cf_d_done", 64'(bus.d_done), 64'd1);
      chk("cf_i_done", 64'(bus.i_done), 64'd0);
      chk("cf_i_miss", 64'(bus.i_miss), 64'd1);
      bus.d_rd = 1'b0;
      tick();
      bus.tx_done = 1'b0;

      // second conflict
      bus.d_rd   = 1'b1;
      bus.d_addr = 32'h0001_0220;
`ifdef SEG_MMU_RR_ARB_EN
      serve("cf2_i", 32'h0001_0008, MEM_RD, 1'b0);
      serve("cf2_d", 32'h0001_0220, MEM_RD, 1'b1);
`else
      serve("cf2_d", 32'h0001_0220, MEM_RD, 1'b1);
      serve("cf2_i", 32'h0001_0008, MEM_RD, 1'b0);
`endif

      // read+write together is a write
      bus.d_rd      = 1'b1;
      bus.d_wr      = 1'b1;
      bus.d_addr    = 32'h0001_0230;
      bus.d_wr_data = 32'hDEAD_BEEF;
      tick();
      chk("wr_wdata", 64'(bus.mem_wr_data), 64'hDEAD_BEEF);
      chk("wr_op", 64'(bus.mem_op), 64'(MEM_WR));
      bus.ready = 1'b1;
      tick();
      bus.ready   = 1'b0;
      bus.tx_done = 1'b1;
      #1;
      chk("wr_done", 64'(bus.d_done), 64'd1);
      bus.d_rd = 1'b0;
      bus.d_wr = 1'b0;
      tick();
      bus.tx_done = 1'b0;

      // reset in WAIT, re-arbitration afterwards
      bus.i_rd   = 1'b1;
      bus.i_addr = 32'h0001_0100;
      tick();
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("rw_op", 64'(bus.mem_op), 64'(MEM_IDLE));
      chk("rw_addr", bus.cpu_addr, 64'h0);
      bus.tx_done = 1'b1;
      #1;
      chk("rw_nodone", 64'({bus.i_done, bus.d_done}), 64'h0);
      bus.tx_done = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.tx_done = 1'b1;
      #1;
      chk("rw_stray", 64'({bus.i_done, bus.d_done}), 64'h0);
      tick();
      chk("rw_rearb_op", 64'(bus.mem_op), 64'(MEM_RD));
      chk("rw_rearb_addr", bus.cpu_addr, 64'h0000_0000_0001_0100);
      #1;
      chk("issue_txd_done", 64'(bus.i_done), 64'd0);
      tick();
      bus.tx_done = 1'b0;
      chk("issue_txd_op", 64'(bus.mem_op), 64'(MEM_RD));
      bus.ready = 1'b1;
      tick();
      bus.ready   = 1'b0;
      bus.tx_done = 1'b1;
      #1;
      chk("rw_done", 64'(bus.i_done), 64'd1);
      bus.i_rd = 1'b0;
      tick();
      bus.tx_done = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

endmodule
